// File: rtl/mips_alu_md.sv
// mips_alu_md: EX-stage ALU with registered results and iterative multiply/divide.
//
// Single-cycle ops (ALU, branch compares, MFHI/MFLO) register their result on
// the accepting edge and pulse out_valid in the next cycle. MULT/MULTU/DIV/DIVU
// run WIDTH shift-add / restoring-divide steps, then write HI/LO in DONE.
//
// Handshake: a request is taken on a rising edge where in_valid & in_ready.
// in_ready is low while busy or in reset; requests made then are dropped.
// out_valid is a one-cycle pulse with no back-pressure.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   opr, a, b           opcode and operands (shifts use b[SHW-1:0])
//   out_valid           result pulse
//   res, ext, zf, of    result, carry/borrow-complement, zero, signed overflow
//   confirm_br          branch condition (branch ops only)
//   hi, lo              architectural HI/LO registers
module mips_alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic             ext,
    output logic             zf,
    output logic             of,
    output logic             confirm_br,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_XOR   = 5'b00101;
    localparam logic [4:0] OP_NOR   = 5'b00110;
    localparam logic [4:0] OP_SLT   = 5'b00111;
    localparam logic [4:0] OP_SLTU  = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b01001;
    localparam logic [4:0] OP_SRL   = 5'b01010;
    localparam logic [4:0] OP_SRA   = 5'b01011;
    localparam logic [4:0] OP_BEQ   = 5'b01100;
    localparam logic [4:0] OP_BNE   = 5'b01101;
    localparam logic [4:0] OP_BGEZ  = 5'b01110;
    localparam logic [4:0] OP_BGTZ  = 5'b01111;
    localparam logic [4:0] OP_BLEZ  = 5'b10000;
    localparam logic [4:0] OP_BLTZ  = 5'b10001;
    localparam logic [4:0] OP_MULT  = 5'b10010;
    localparam logic [4:0] OP_MULTU = 5'b10011;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_MFHI  = 5'b10110;
    localparam logic [4:0] OP_MFLO  = 5'b10111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [SHW-1:0]       cnt;
    // MUL: {partial product high, multiplier shifting out}.
    // DIV: {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     dvd_raw;   // original dividend, returned in HI on divide by zero
    logic                 is_div;
    logic                 neg_q;     // negate product / quotient at DONE
    logic                 neg_r;     // negate remainder at DONE (dividend sign)
    logic                 div_zero;

    logic accept;
    assign in_ready = (state == IDLE) & ~rst;
    assign accept   = in_valid & in_ready;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [SHW-1:0]   shamt;
    logic             a_neg;
    logic             a_zero;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ext;
    logic             sc_of;
    logic             sc_br;
    logic             sc_zf;
    logic             sc_def;

    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = b[SHW-1:0];
        a_neg   = a[WIDTH-1];
        a_zero  = (a == '0);
        sc_res  = '0;
        sc_ext  = 1'b0;
        sc_of   = 1'b0;
        sc_br   = 1'b0;
        sc_def  = 1'b1;
        case (opr)
            OP_ADD: begin
                sc_res = sum_add[WIDTH-1:0];
                sc_ext = sum_add[WIDTH];
                sc_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sum_sub[WIDTH-1:0];
                sc_ext = sum_sub[WIDTH];
                sc_of  = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(a) >>> shamt);
            OP_BEQ:  sc_br  = (a == b);
            OP_BNE:  sc_br  = (a != b);
            OP_BGEZ: sc_br  = ~a_neg;
            OP_BGTZ: sc_br  = ~a_neg & ~a_zero;
            OP_BLEZ: sc_br  = a_neg | a_zero;
            OP_BLTZ: sc_br  = a_neg;
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            default: sc_def = 1'b0;
        endcase
        // Undefined opcodes report every flag as 0, including zf.
        sc_zf = sc_def && (sc_res == '0);
    end

    // ---------------- multiply/divide setup ----------------
    logic             is_md_op;
    logic             is_div_op;
    logic             op_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        is_div_op = (opr == OP_DIV) || (opr == OP_DIVU);
        is_md_op  = is_div_op || (opr == OP_MULT) || (opr == OP_MULTU);
        op_signed = (opr == OP_MULT) || (opr == OP_DIV);
        // The most-negative value keeps its bit pattern, which is its correct
        // unsigned magnitude.
        mag_a = (op_signed && a[WIDTH-1]) ? -a : a;
        mag_b = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    // ---------------- iterative step and final fix-up ----------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   done_hi;
    logic [WIDTH-1:0]   done_lo;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the difference is
        // a reliable "did not fit" flag (except when dividing by zero, which is
        // overridden at DONE).
        div_diff = div_sh - {1'b0, opnd};
        if (state == MUL) begin
            step_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            step_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end

        prod = neg_q ? -acc : acc;
        if (!is_div) begin
            done_hi = prod[2*WIDTH-1:WIDTH];
            done_lo = prod[WIDTH-1:0];
        end else if (div_zero) begin
            done_hi = dvd_raw;
            done_lo = '1;
        end else begin
            done_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            done_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    // ---------------- FSM and output registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            dvd_raw    <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            out_valid  <= 1'b0;
            res        <= '0;
            ext        <= 1'b0;
            zf         <= 1'b0;
            of         <= 1'b0;
            confirm_br <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_md_op) begin
                            cnt      <= '0;
                            is_div   <= is_div_op;
                            neg_q    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r    <= op_signed & a[WIDTH-1];
                            div_zero <= (b == '0);
                            dvd_raw  <= a;
                            if (is_div_op) begin
                                acc   <= {{WIDTH{1'b0}}, mag_a};
                                opnd  <= mag_b;
                                state <= DIV;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, mag_b};
                                opnd  <= mag_a;
                                state <= MUL;
                            end
                        end else begin
                            out_valid  <= 1'b1;
                            res        <= sc_res;
                            ext        <= sc_ext;
                            zf         <= sc_zf;
                            of         <= sc_of;
                            confirm_br <= sc_br;
                        end
                    end
                end
                MUL, DIV: begin
                    acc <= step_next;
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi         <= done_hi;
                    lo         <= done_lo;
                    res        <= done_lo;
                    ext        <= 1'b0;
                    zf         <= 1'b0;
                    of         <= 1'b0;
                    confirm_br <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
